// File: rtl/cla_pkg.sv
// Shared width constants for the 4-bit carry-lookahead adder and anything that cascades it.
package cla_pkg;

    localparam int unsigned CLA_W     = 4;
    localparam int unsigned CLA_RES_W = CLA_W + 1;

endpackage

// File: rtl/cla_logic.sv
// Combinational 4-bit carry-lookahead core; G/P are exported so wider adders can build group lookahead on top.
import cla_pkg::*;

module cla_logic (
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             Cin,
    output logic [CLA_W-1:0] S,
    output logic             Cout,
    output logic             G,
    output logic             P
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] c;

    always_comb begin
        g = A & B;
        p = A ^ B;

        // Every carry is a flat sum-of-products of g/p/Cin; no carry feeds another.
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

        G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P = p[3] & p[2] & p[1] & p[0];

        Cout = G | (P & Cin);
        S    = p ^ c;
    end

endmodule

// File: rtl/cla.sv
// Registered 4-bit add-with-carry: Q captures {Cout, S} of A + B + Cin on enabled edges.
import cla_pkg::*;

module cla (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CLA_W-1:0]     A,
    input  logic [CLA_W-1:0]     B,
    input  logic                 Cin,
    output logic [CLA_RES_W-1:0] Q
);

    logic [CLA_W-1:0] sum;
    logic             cout;
    // Group terms are only consumed by wider cascades, not by this register.
    logic             grp_g_unused;
    logic             grp_p_unused;

    cla_logic u_logic (
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (sum),
        .Cout (cout),
        .G    (grp_g_unused),
        .P    (grp_p_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q <= '0;
        end else if (load) begin
            Q <= {cout, sum};
        end
    end

endmodule

// File: tb/tb_cla.sv
// Directed and exhaustive bench for cla with a scoreboard of expected register values.
module tb_cla;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [4:0] Q;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [4:0]  exp_q[$];

    cla dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b} + {4'b0, c};
        return r;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive on the falling edge; with load high the model result goes to the scoreboard.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic ld);
        @(negedge clk);
        A    = a;
        B    = b;
        Cin  = c;
        load = ld;
        if (ld) exp_q.push_back(model_sum(a, b, c));
    endtask

    task automatic step_check(input string tag);
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty-scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, Q, e);
        end
    endtask

    task automatic add(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c);
        drive(a, b, c, 1'b1);
        step_check(tag);
    endtask

    initial begin
        logic exp_g;
        logic exp_p;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        load  = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;

        // Asynchronous reset between edges
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("reset_async", Q, 5'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        add("zero_add", 4'd0, 4'd0, 1'b0);
        add("sum_0_5", 4'd0, 4'd5, 1'b0);
        add("sum_5_7", 4'd5, 4'd7, 1'b0);
        add("sum_9_4", 4'd9, 4'd4, 1'b0);
        add("carry_8_7_1", 4'd8, 4'd7, 1'b1);
        add("carry_8_8_1", 4'd8, 4'd8, 1'b1);
        add("carry_13_10_1", 4'd13, 4'd10, 1'b1);
        add("carry_14_15_0", 4'd14, 4'd15, 1'b0);

        // Hold: load low for three edges keeps the captured 12
        add("hold_capture", 4'd5, 4'd7, 1'b0);
        drive(4'd15, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("hold_q", Q, 5'd12);
        end
        add("hold_release_31", 4'd15, 4'd15, 1'b1);

        // Reset pulse between edges, then reload of the current sum
        add("pre_reset_29", 4'd14, 4'd15, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("reset_mid", Q, 5'd0);
        #1 reset = 1'b0;
        #1 check("reset_mid_released", Q, 5'd0);
        add("reload_after_reset", 4'd14, 4'd15, 1'b0);

        // Reset held across an enabled edge wins over the capture
        @(negedge clk);
        A = 4'd9; B = 4'd9; Cin = 1'b1; load = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 check("reset_beats_load", Q, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(model_sum(4'd9, 4'd9, 1'b1));
        step_check("first_load_after_reset");

        // Exhaustive sweep, including group generate/propagate
        for (int unsigned v = 0; v < 512; v++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            a = v[3:0];
            b = v[7:4];
            c = v[8];
            drive(a, b, c, 1'b1);
            #1;
            exp_g = ({1'b0, a} + {1'b0, b}) > 5'd15;
            exp_p = ((a ^ b) == 4'hF);
            check("group_g", {4'b0, dut.u_logic.G}, {4'b0, exp_g});
            check("group_p", {4'b0, dut.u_logic.P}, {4'b0, exp_p});
            step_check("exhaustive");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
